// File: rtl/serial_adder_fsm.sv
// Bit-serial unsigned adder. Operands are latched on an accepted start and
// summed LSB-first through a one-bit full-adder cell with a registered carry.
// The N-bit sum and carry-out are presented with a one-cycle done strobe.
module serial_adder_fsm #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s;
   logic             c_next;

   // One-bit full-adder cell on the current LSB of the operand shift registers
   always_comb begin
      s      = a_sh[0] ^ b_sh[0] ^ carry;
      c_next = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   end

   // Control FSM, operand/sum shift registers and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh      <= a;
                  b_sh      <= b;
                  carry     <= 1'b0;
                  cnt       <= '0;
                  carry_out <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               sum   <= {s, sum[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= c_next;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  carry_out <= c_next;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed and random checks of serial_adder_fsm at WIDTH=8 and WIDTH=16.
module tb_serial_adder_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start8, start16;
   logic [7:0]  a8, b8, sum8;
   logic [15:0] a16, b16, sum16;
   logic        busy8, done8, co8, busy16, done16, co16;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   serial_adder_fsm #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8)
   );

   serial_adder_fsm #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .sum(sum16), .carry_out(co16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation on the selected instance; checks latency, busy width and result.
   task automatic run_op(input int unsigned w, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_sum, input logic exp_co);
      int unsigned n, bcnt;
      logic d, bz;
      if (w == 8) begin a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1; end
      else begin a16 = x[15:0]; b16 = y[15:0]; start16 = 1'b1; end
      tick();
      start8 = 1'b0; start16 = 1'b0;
      n = 0; bcnt = 0;
      d  = (w == 8) ? done8 : done16;
      bz = (w == 8) ? busy8 : busy16;
      while (!d && n < 40) begin
         if (bz) bcnt++;
         tick();
         n++;
         d  = (w == 8) ? done8 : done16;
         bz = (w == 8) ? busy8 : busy16;
      end
      check("latency", n, w);
      check("busy_cycles", bcnt, w);
      if (w == 8) begin
         check("sum8", {24'h0, sum8}, exp_sum);
         check("co8", {31'h0, co8}, {31'h0, exp_co});
      end else begin
         check("sum16", {16'h0, sum16}, exp_sum);
         check("co16", {31'h0, co16}, {31'h0, exp_co});
      end
      tick();
      check("done_one_cycle", (w == 8) ? done8 : done16, 1'b0);
   endtask

   initial begin
      int unsigned dcount, t1, t2, ndone;
      logic [7:0]  s_seen, r1, r2;
      logic        c_seen, c1, c2;
      logic [31:0] x, y, tot;

      rst_n = 1'b0; start8 = 0; start16 = 0;
      a8 = 0; b8 = 0; a16 = 0; b16 = 0;
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_busy", busy8, 1'b0);
         check("rst_done", done8, 1'b0);
         check("rst_sum", {24'h0, sum8}, 32'h0);
         check("rst_co", co8, 1'b0);
      end

      run_op(8, 32'h00, 32'h00, 32'h00, 1'b0);
      run_op(8, 32'hFF, 32'h01, 32'h00, 1'b1);
      run_op(8, 32'hA5, 32'h5A, 32'hFF, 1'b0);
      run_op(8, 32'hFF, 32'hFF, 32'hFE, 1'b1);

      // Ignored start and operand isolation
      a8 = 8'h3C; b8 = 8'h0F; start8 = 1'b1;
      tick();
      dcount = 0; s_seen = 0; c_seen = 0;
      for (int i = 1; i <= 20; i++) begin
         if (i == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
         else begin start8 = 1'b0; a8 = ~a8; b8 = b8 ^ 8'h55; end
         tick();
         if (done8) begin dcount++; s_seen = sum8; c_seen = co8; end
      end
      check("iso_done_count", dcount, 1);
      check("iso_sum", {24'h0, s_seen}, 32'h4B);
      check("iso_co", c_seen, 1'b0);
      check("iso_idle_busy", busy8, 1'b0);
      check("iso_hold_sum", {24'h0, sum8}, 32'h4B);

      // Reset mid-operation
      a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_busy", busy8, 1'b0);
      check("midrst_sum", {24'h0, sum8}, 32'h0);
      check("midrst_co", co8, 1'b0);
      dcount = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done8) dcount++;
      end
      check("midrst_no_done", dcount, 0);
      run_op(8, 32'h80, 32'h80, 32'h00, 1'b1);

      // Back-to-back with start held high
      a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      ndone = 0; t1 = 0; t2 = 0; r1 = 0; r2 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < 40 && ndone < 2; i++) begin
         tick();
         if (done8) begin
            if (ndone == 0) begin
               t1 = i; r1 = sum8; c1 = co8;
               a8 = 8'hF0; b8 = 8'h20;
            end else begin
               t2 = i; r2 = sum8; c2 = co8;
               start8 = 1'b0;
            end
            ndone++;
         end
      end
      start8 = 1'b0;
      check("b2b_count", ndone, 2);
      check("b2b_sum1", {24'h0, r1}, 32'h46);
      check("b2b_co1", c1, 1'b0);
      check("b2b_sum2", {24'h0, r2}, 32'h10);
      check("b2b_co2", c2, 1'b1);
      check("b2b_spacing", t2 - t1, 10);
      tick(); tick();

      // Random pairs against a reference sum
      for (int i = 0; i < 1000; i++) begin
         x = {24'h0, 8'($urandom)};
         y = {24'h0, 8'($urandom)};
         tot = x + y;
         run_op(8, x, y, tot & 32'hFF, tot[8]);
      end
      for (int i = 0; i < 1000; i++) begin
         x = {16'h0, 16'($urandom)};
         y = {16'h0, 16'($urandom)};
         tot = x + y;
         run_op(16, x, y, tot & 32'hFFFF, tot[16]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
